// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in/serial-out shifter, advanced by a bit-rate strobe.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic [WIDTH-1:0] shift_reg,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  // Zero fill drains the shifter so serial_out idles low without extra gating.
  assign sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && in_valid) begin
        sr_q    <= par_in;
        cnt_q   <= '0;
        state_q <= SHIFT;
      end else if (state_q == SHIFT && shift_en) begin
        sr_q <= sr_d;
        if (cnt_q == CW'(WIDTH - 1)) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
  assign in_ready     = state_q == IDLE;
  assign serial_valid = state_q == SHIFT;
  assign serial_out   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign shift_reg    = sr_q;
  assign done         = done_q;
endmodule
